ram_scan_ctrl: RTL and testbench
================================

# ram_scan_ctrl

Sequencer and arbiter for the Lab 2 32×4 memory block. It shares the single RAM port between a user write path and an automatic read scanner. The scanner steps through all 32 addresses at a fixed tick rate. Each completed read is latched into display registers that feed the address and data 7-segment decoders (HEX5/HEX4 address, HEX0 data). User writes have priority over scan reads and never corrupt a read in flight.

## Interface
Parameters:
- ADDR_W, 5, RAM address width (32 words)
- DATA_W, 4, RAM data width
- TICK_DIV, 50_000_000, clk cycles per scan step (1 s at 50 MHz); must be ≥ 4

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- scan_en  in  1  1 = scanner advances on ticks; 0 = scanner paused, writes still served
- wr_req  in  1  write request level, synchronous to clk (debounced key); a rising edge requests one write
- wr_addr  in  ADDR_W  write address, sampled on wr_req rising edge
- wr_data  in  DATA_W  write data, sampled on wr_req rising edge
- ram_rdata  in  DATA_W  RAM read data; valid the cycle after address is registered
- ram_addr  out  ADDR_W  RAM address (RAM registers it on clk)
- ram_wdata  out  DATA_W  RAM write data
- ram_wren  out  1  RAM write enable, one cycle per write
- disp_addr  out  ADDR_W  address of last completed read, to 7-seg decoder
- disp_data  out  DATA_W  data of last completed read, to 7-seg decoder
- disp_valid  out  1  set after first completed read; stays set until reset
- wr_done  out  1  one-cycle pulse in the cycle after ram_wren was high

## Operation
- Reset values: all outputs 0; state IDLE; scan_ptr 0; tick counter 0; wr_pend, tick_pend and refresh flags 0.
- Tick counter: runs 0..TICK_DIV-1 while scan_en=1. Tick is asserted when the count is TICK_DIV-1, and the counter then wraps to 0. While scan_en=0, the counter is held at 0 and no ticks occur.
- Write capture:
  - Edge = wr_req & ~wr_req_q.
  - On an edge, wr_addr and wr_data are latched and wr_pend is set.
  - A new edge while wr_pend=1 overwrites the latched values; the latest request wins and only one write is issued.
- Tick capture: a tick sets tick_pend. tick_pend clears when a scan read starts. Ticks arriving while tick_pend=1 are merged.
- FSM states: IDLE, WRITE, READ, CAPTURE.
  - IDLE: ram_addr=scan_ptr, ram_wren=0. Priority: wr_pend → WRITE; else refresh → READ (refresh read); else tick_pend → READ (scan read); else stay in IDLE.
  - WRITE: ram_addr/ram_wdata = latched values, ram_wren=1. Clear wr_pend. If latched addr == disp_addr and disp_valid=1, set refresh. Next state IDLE.
  - READ: ram_addr = disp_addr for a refresh read, or scan_ptr for a scan read; ram_wren=0. Next state CAPTURE.
  - CAPTURE: at cycle end, disp_data←ram_rdata and disp_valid←1.
    - Scan read: disp_addr←scan_ptr; scan_ptr←scan_ptr+1 mod 2^ADDR_W (31→0).
    - Refresh read: disp_addr unchanged; scan_ptr unchanged; clear refresh.
    - Next state IDLE.
- A write edge arriving during READ or CAPTURE waits; the read completes first.
- Reset asserted mid-operation: all state and outputs return to reset values asynchronously. Pending write and tick are discarded, and no partial write is issued after reset deasserts.

## Timing
- Write latency: wr_req edge at cycle N → wr_pend set at end of N → ram_wren=1 in N+1 (if IDLE) → wr_done=1 in N+2.
- Scan read: tick in cycle T (FSM IDLE, no pending write) → READ in T+1 → CAPTURE in T+2 → disp_* updated, visible in T+3.
- Tick and write edge in the same cycle: WRITE first, then READ/CAPTURE. disp_* are updated 2 cycles later than in the scan-read case.
- Worst-case service for one write + refresh + scan read: 7 cycles. TICK_DIV ≥ 4 guarantees no tick is lost except by the stated merging.
- ram_wren is never high in READ or CAPTURE. At most one RAM operation starts per cycle.

## Test plan (TICK_DIV=4)
- Reset then scan_en=1, RAM preloaded with mem[i]=i[3:0]:
  - successive disp_addr = 0,1,2,…; disp_data = 0,1,2,…;
  - an update every 4 cycles;
  - disp_valid rises with the first capture.
- Run scanner through 32 steps: disp_addr goes 31 then 0; scan_ptr wraps; no X on outputs.
- wr_req edge with wr_addr=5, wr_data=4'hA, scanner paused:
  - ram_wren one cycle with ram_addr=5, ram_wdata=A;
  - wr_done the next cycle;
  - a later scan shows disp_addr=5, disp_data=A.
- Write edge in the same cycle as a tick: WRITE precedes READ; no overlap of ram_wren with READ; disp_* updated 4 cycles after the tick.
- disp_addr=7 displayed, then write addr 7 data 4'h3: a refresh read follows; disp_data becomes 3 with disp_addr still 7; scan_ptr unchanged.
- Assert reset during WRITE pending (wr_pend=1) and during CAPTURE:
  - all outputs go to 0 immediately;
  - no ram_wren after deassertion until a new wr_req edge.

Source files
------------

// File: rtl/ram_scan_ctrl.sv
// ram_scan_ctrl
// Shares one synchronous RAM port between a user write path and an
// automatic read scanner. The scanner reads one address per tick and walks
// all 2^ADDR_W words. Each completed read is latched into display registers
// that drive the address/data 7-segment decoders. Writes take priority over
// scan reads but never interrupt a read that has already started. A write
// to the displayed address triggers a refresh read so the display tracks RAM.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   scan_en             1 = scanner advances on ticks, 0 = paused
//   wr_req              write request level; rising edge requests one write
//   wr_addr, wr_data    write address/data, sampled on the wr_req edge
//   ram_rdata           RAM read data, valid the cycle after ram_addr is registered
//   ram_addr, ram_wdata RAM address / write data
//   ram_wren            RAM write enable, one cycle per write
//   disp_addr/disp_data address/data of the last completed read
//   disp_valid          set after the first completed read
//   wr_done             one-cycle pulse in the cycle after ram_wren
module ram_scan_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_en,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              wr_done
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  tick_cnt;
    logic [ADDR_W-1:0] scan_ptr;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              wr_req_q;
    logic              wr_pend;
    logic              tick_pend;
    logic              refresh;
    logic              rd_refresh;   // read in flight is a refresh, not a scan

    logic              tick;
    logic              wr_edge;
    logic              wr_pend_n;
    logic              tick_pend_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [DATA_W-1:0] wr_data_n;

    assign tick    = scan_en && (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign wr_edge = wr_req & ~wr_req_q;

    // IDLE looks through the capture registers so a request arriving in an
    // idle cycle is served on the very next cycle; a same-cycle edge carries
    // the newest address/data.
    assign wr_pend_n   = wr_pend | wr_edge;
    assign tick_pend_n = tick_pend | tick;
    assign wr_addr_n   = wr_edge ? wr_addr : wr_addr_q;
    assign wr_data_n   = wr_edge ? wr_data : wr_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            scan_ptr   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_req_q   <= 1'b0;
            wr_pend    <= 1'b0;
            tick_pend  <= 1'b0;
            refresh    <= 1'b0;
            rd_refresh <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_wren   <= 1'b0;
            disp_addr  <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            wr_done    <= 1'b0;
        end else begin
            wr_req_q <= wr_req;
            wr_done  <= ram_wren;
            ram_wren <= 1'b0;

            if (!scan_en || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 1'b1;

            // Latest request wins while a write is still pending.
            if (wr_edge) begin
                wr_addr_q <= wr_addr;
                wr_data_q <= wr_data;
                wr_pend   <= 1'b1;
            end
            if (tick)
                tick_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (wr_pend_n) begin
                        state     <= WRITE;
                        ram_addr  <= wr_addr_n;
                        ram_wdata <= wr_data_n;
                        ram_wren  <= 1'b1;
                    end else if (refresh) begin
                        state      <= READ;
                        rd_refresh <= 1'b1;
                        ram_addr   <= disp_addr;
                    end else if (tick_pend_n) begin
                        // Ticks landing before the read starts merge into it.
                        state      <= READ;
                        rd_refresh <= 1'b0;
                        ram_addr   <= scan_ptr;
                        tick_pend  <= 1'b0;
                    end
                end
                WRITE: begin
                    // An edge during WRITE is a fresh request and stays pending.
                    wr_pend <= wr_edge;
                    if (disp_valid && ram_addr == disp_addr)
                        refresh <= 1'b1;
                    state    <= IDLE;
                    ram_addr <= scan_ptr;
                end
                READ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    disp_data  <= ram_rdata;
                    disp_valid <= 1'b1;
                    if (rd_refresh) begin
                        refresh  <= 1'b0;
                        ram_addr <= scan_ptr;
                    end else begin
                        disp_addr <= scan_ptr;
                        scan_ptr  <= scan_ptr + 1'b1;
                        ram_addr  <= scan_ptr + 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Directed bench for ram_scan_ctrl with TICK_DIV=4 and a behavioural 32x4
// synchronous RAM preloaded with mem[i] = i[3:0]. Cycle c is the interval
// after the c-th rising edge following reset release; inputs are driven and
// outputs sampled 1 ns after each rising edge.
module tb_ram_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_en;
    logic       wr_req;
    logic [4:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] ram_rdata;
    logic [4:0] ram_addr;
    logic [3:0] ram_wdata;
    logic       ram_wren;
    logic [4:0] disp_addr;
    logic [3:0] disp_data;
    logic       disp_valid;
    logic       wr_done;

    logic [3:0] mem [32];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = -3;

    ram_scan_ctrl #(.ADDR_W(5), .DATA_W(4), .TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .scan_en(scan_en),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wren(ram_wren), .disp_addr(disp_addr), .disp_data(disp_data),
        .disp_valid(disp_valid), .wr_done(wr_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c)
            step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, " ram_addr"}, 32'(ram_addr), 0);
        chk({tag, " ram_wren"}, 32'(ram_wren), 0);
        chk({tag, " ram_wdata"}, 32'(ram_wdata), 0);
        chk({tag, " disp_addr"}, 32'(disp_addr), 0);
        chk({tag, " disp_data"}, 32'(disp_data), 0);
        chk({tag, " disp_valid"}, 32'(disp_valid), 0);
        chk({tag, " wr_done"}, 32'(wr_done), 0);
    endtask

    task automatic chk_disp(input string tag, input int a, input int d);
        chk({tag, " disp_addr"}, 32'(disp_addr), 32'(a));
        chk({tag, " disp_data"}, 32'(disp_data), 32'(d));
        chk({tag, " disp_valid"}, 32'(disp_valid), 1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            mem[i] = 4'(i);
        reset   = 1'b1;
        scan_en = 1'b0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        // Reset state
        goto(0);
        chk_zero_outs("reset");
        reset   = 1'b0;
        scan_en = 1'b1;

        // Scanner: tick in cycle 3+4i, disp shows address i from cycle 6+4i
        for (int c = 1; c <= 134; c++) begin
            goto(c);
            chk("noX", 32'($isunknown({ram_addr, ram_wren, disp_addr, disp_data, disp_valid, wr_done})), 0);
            if (c == 5)
                chk("valid_before_first", 32'(disp_valid), 0);
            if (c >= 6 && (c - 6) % 4 == 0)
                chk_disp("scan", ((c - 6) / 4) % 32, ((c - 6) / 4) % 16);
            if (c == 9)
                chk("hold_between_ticks", 32'(disp_addr), 0);
        end
        chk_disp("wrap", 0, 0);
        scan_en = 1'b0;

        // Paused write of A to address 5
        goto(136);
        wr_req = 1'b1; wr_addr = 5'd5; wr_data = 4'hA;
        step();
        chk("wr ram_wren", 32'(ram_wren), 1);
        chk("wr ram_addr", 32'(ram_addr), 5);
        chk("wr ram_wdata", 32'(ram_wdata), 32'hA);
        chk("wr wr_done_early", 32'(wr_done), 0);
        step();
        wr_req = 1'b0;
        chk("wr ram_wren_one", 32'(ram_wren), 0);
        chk("wr wr_done", 32'(wr_done), 1);
        step();
        chk("wr wr_done_pulse", 32'(wr_done), 0);
        chk("wr disp_untouched", 32'(disp_addr), 0);

        // Resume: scan_ptr 1 -> 5, address 5 now holds A
        goto(140);
        scan_en = 1'b1;
        goto(162);
        chk_disp("scan_after_wr", 5, 32'hA);

        // Tick and write edge together in cycle 163
        goto(163);
        wr_req = 1'b1; wr_addr = 5'd10; wr_data = 4'h6;
        step();
        chk("tw ram_wren", 32'(ram_wren), 1);
        chk("tw ram_addr", 32'(ram_addr), 10);
        step();
        wr_req = 1'b0;
        chk("tw wr_done", 32'(wr_done), 1);
        chk("tw wren_idle", 32'(ram_wren), 0);
        step();
        chk("tw wren_read", 32'(ram_wren), 0);
        chk("tw read_addr", 32'(ram_addr), 6);
        step();
        chk("tw wren_capture", 32'(ram_wren), 0);
        chk("tw disp_not_yet", 32'(disp_addr), 5);
        step();
        chk_disp("tw disp", 6, 6);
        scan_en = 1'b0;
        goto(171);
        chk_disp("disp7", 7, 7);

        // Write to the displayed address 7 -> refresh read
        goto(172);
        wr_req = 1'b1; wr_addr = 5'd7; wr_data = 4'h3;
        step();
        chk("rf ram_wren", 32'(ram_wren), 1);
        goto(174);
        wr_req = 1'b0;
        step();
        chk("rf read_addr", 32'(ram_addr), 7);
        step();
        chk("rf disp_old", 32'(disp_data), 7);
        step();
        chk_disp("rf disp", 7, 3);
        chk("rf scan_ptr_kept", 32'(ram_addr), 8);
        step();
        scan_en = 1'b1;
        goto(184);
        chk_disp("rf next_scan", 8, 8);

        // Reset during CAPTURE with a write pending (edge arrived in READ)
        goto(186);
        wr_req = 1'b1; wr_addr = 5'd3; wr_data = 4'hF;
        step();
        chk("rA in_capture_addr", 32'(ram_addr), 9);
        #2;
        reset = 1'b1; wr_req = 1'b0; scan_en = 1'b0;
        #1;
        chk_zero_outs("rA async");
        step();
        reset = 1'b0;
        for (int c = 189; c <= 196; c++) begin
            goto(c);
            chk("rA no_wren", 32'(ram_wren), 0);
        end
        chk("rA valid_cleared", 32'(disp_valid), 0);
        chk("rA no_write_mem3", 32'(mem[3]), 3);

        // Reset while ram_wren is high
        goto(198);
        wr_req = 1'b1; wr_addr = 5'd9; wr_data = 4'h5;
        step();
        chk("rB wren_before", 32'(ram_wren), 1);
        #2;
        reset = 1'b1; wr_req = 1'b0;
        #1;
        chk_zero_outs("rB async");
        step();
        reset = 1'b0;
        for (int c = 201; c <= 205; c++) begin
            goto(c);
            chk("rB no_wren", 32'(ram_wren), 0);
            chk("rB no_done", 32'(wr_done), 0);
        end
        chk("rB no_write_mem9", 32'(mem[9]), 9);

        // Two edges before service: only the latest is written, once
        goto(206);
        scan_en = 1'b1;
        goto(210);
        scan_en = 1'b0;
        wr_req = 1'b1; wr_addr = 5'd13; wr_data = 4'h1;
        step();
        wr_req = 1'b0;
        chk("mg wren_capture", 32'(ram_wren), 0);
        step();
        wr_req = 1'b1; wr_addr = 5'd12; wr_data = 4'h2;
        chk_disp("mg scan_from_0", 0, 0);
        step();
        chk("mg ram_wren", 32'(ram_wren), 1);
        chk("mg ram_addr", 32'(ram_addr), 12);
        chk("mg ram_wdata", 32'(ram_wdata), 2);
        step();
        chk("mg one_write", 32'(ram_wren), 0);
        chk("mg wr_done", 32'(wr_done), 1);
        step();
        chk("mg no_second", 32'(ram_wren), 0);
        chk("mg mem13_untouched", 32'(mem[13]), 13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
